// File: rtl/conv_pass_sequencer_pkg.sv
// Shared constants and state encoding for the convolution pass sequencer.
// Image geometry is shared with the conv engine; plane size sets the per-pass
// base step for both source and destination images.
package conv_pass_sequencer_pkg;

  localparam int SEQ_ADDR_W         = 17;
  localparam int SEQ_PASS_W         = 8;
  localparam int IMG_ROWS           = 50;
  localparam int IMG_COLS           = 50;
  localparam int IMG_WORDS          = IMG_ROWS * IMG_COLS;
  localparam int SEQ_DRAIN_CYCLES   = 2;
  localparam int SEQ_TIMEOUT_CYCLES = 65535;
  localparam int SEQ_WDOG_W         = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/conv_pass_sequencer_if.sv
// Host + engine + memory signal bundle for the pass sequencer.
// slave: sequencer view. master: host/engine/memory environment view.
interface conv_pass_sequencer_if #(
  parameter int ADDR_W = conv_pass_sequencer_pkg::SEQ_ADDR_W,
  parameter int PASS_W = conv_pass_sequencer_pkg::SEQ_PASS_W
);
  // host side
  logic              go;
  logic [PASS_W-1:0] cfg_num_pass;
  logic [ADDR_W-1:0] cfg_src_base;
  logic [ADDR_W-1:0] cfg_dst_base;
  logic              busy;
  logic              done;
  logic              err;
  logic [PASS_W-1:0] pass_idx;
  // engine side
  logic              conv_rst;
  logic              conv_start;
  logic              conv_ready;
  logic [ADDR_W-1:0] conv_raddr;
  logic [ADDR_W-1:0] conv_waddr;
  logic              conv_we;
  // image memory side
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_we;

  modport slave (
    input  go, cfg_num_pass, cfg_src_base, cfg_dst_base,
    input  conv_ready, conv_raddr, conv_waddr, conv_we,
    output busy, done, err, pass_idx,
    output conv_rst, conv_start,
    output mem_raddr, mem_waddr, mem_we
  );

  modport master (
    output go, cfg_num_pass, cfg_src_base, cfg_dst_base,
    output conv_ready, conv_raddr, conv_waddr, conv_we,
    input  busy, done, err, pass_idx,
    input  conv_rst, conv_start,
    input  mem_raddr, mem_waddr, mem_we
  );
endinterface

// File: rtl/conv_pass_sequencer_addr_offset.sv
// Relocates the engine's plane-local addresses into the shared image memory
// and blocks engine writes outside the active part of a pass.
module conv_addr_offset #(
  parameter int ADDR_W = 17
) (
  input  logic [ADDR_W-1:0] i_conv_raddr,
  input  logic [ADDR_W-1:0] i_conv_waddr,
  input  logic              i_conv_we,
  input  logic [ADDR_W-1:0] i_src_cur,
  input  logic [ADDR_W-1:0] i_dst_cur,
  input  logic              i_we_en,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic              o_mem_we
);

  // Sums truncate to ADDR_W, so addresses wrap around the memory.
  assign o_mem_raddr = i_conv_raddr + i_src_cur;
  assign o_mem_waddr = i_conv_waddr + i_dst_cur;
  assign o_mem_we    = i_conv_we & i_we_en;

endmodule

// File: rtl/conv_pass_sequencer.sv
// Runs the conv engine once per image plane: clear, start, wait ready, drain
// the trailing write, then step source/destination bases by one plane.
// Optional RUN watchdog: define SEQ_TIMEOUT_EN.
module conv_pass_sequencer #(
  parameter int ADDR_W         = conv_pass_sequencer_pkg::SEQ_ADDR_W,
  parameter int PASS_W         = conv_pass_sequencer_pkg::SEQ_PASS_W,
  parameter int IMG_WORDS      = conv_pass_sequencer_pkg::IMG_WORDS,
  parameter int DRAIN_CYCLES   = conv_pass_sequencer_pkg::SEQ_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = conv_pass_sequencer_pkg::SEQ_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  conv_pass_sequencer_if.slave         io_seq
);
  import conv_pass_sequencer_pkg::*;

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  seq_state_e        r_state, w_state_nxt;
  logic [PASS_W-1:0] r_num_pass;
  logic [PASS_W-1:0] r_pass_idx;
  logic [ADDR_W-1:0] r_src_cur;
  logic [ADDR_W-1:0] r_dst_cur;
  logic [DRAIN_W-1:0] r_drain;

  logic w_go_ok;
  logic w_last;
  logic w_drain_end;
  logic w_timeout;
  logic w_busy;
  logic w_done;
  logic w_start;
  logic w_clr;
  logic w_we_en;
  logic w_to_rst;

  assign w_go_ok     = io_seq.go && (io_seq.cfg_num_pass != '0);
  assign w_last      = (r_pass_idx == r_num_pass - 1'b1);
  assign w_drain_end = (r_drain == '0);

`ifdef SEQ_TIMEOUT_EN
  logic [SEQ_WDOG_W-1:0] r_wdog;
  logic                  r_err;
  logic                  r_to_rst;

  assign w_timeout = (r_state == S_RUN) && !io_seq.conv_ready &&
                     (r_wdog == SEQ_WDOG_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: zeroed on the way into RUN, counts every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)                    r_wdog <= '0;
    else if (r_state == S_START) r_wdog <= '0;
    else if (r_state == S_RUN)   r_wdog <= r_wdog + 1'b1;
  end

  // Sticky error until the next accepted job; engine gets a one-cycle reset
  // alongside the abort so it does not keep chewing on a dead pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_to_rst <= 1'b0;
    end else begin
      r_to_rst <= w_timeout;
      if (w_timeout)                          r_err <= 1'b1;
      else if (r_state == S_IDLE && w_go_ok)  r_err <= 1'b0;
    end
  end

  assign io_seq.err = r_err;
  assign w_to_rst   = r_to_rst;
`else
  assign w_timeout  = 1'b0;
  assign w_to_rst   = 1'b0;
  assign io_seq.err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs. A zero-pass go goes straight to
  // DONE so the host still sees completion without touching the engine.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_start     = 1'b0;
    w_clr       = 1'b0;
    w_we_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_seq.go) w_state_nxt = (io_seq.cfg_num_pass != '0) ? S_CLR : S_DONE;
      end
      S_CLR: begin
        w_busy      = 1'b1;
        w_clr       = 1'b1;
        w_state_nxt = S_START;
      end
      S_START: begin
        w_busy      = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_we_en = 1'b1;
        if (io_seq.conv_ready) w_state_nxt = S_DRAIN;
        else if (w_timeout)    w_state_nxt = S_DONE;
      end
      S_DRAIN: begin
        w_busy  = 1'b1;
        w_we_en = 1'b1;
        if (w_drain_end) w_state_nxt = w_last ? S_DONE : S_CLR;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job configuration, per-pass bases and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_pass <= '0;
      r_pass_idx <= '0;
      r_src_cur  <= '0;
      r_dst_cur  <= '0;
      r_drain    <= '0;
    end else begin
      if (r_state == S_IDLE && w_go_ok) begin
        r_num_pass <= io_seq.cfg_num_pass;
        r_pass_idx <= '0;
        r_src_cur  <= io_seq.cfg_src_base;
        r_dst_cur  <= io_seq.cfg_dst_base;
      end else if (r_state == S_DRAIN && w_drain_end && !w_last) begin
        r_pass_idx <= r_pass_idx + 1'b1;
        r_src_cur  <= r_src_cur + ADDR_W'(IMG_WORDS);
        r_dst_cur  <= r_dst_cur + ADDR_W'(IMG_WORDS);
      end
      if (r_state == S_RUN && io_seq.conv_ready)
        r_drain <= DRAIN_W'(DRAIN_CYCLES - 1);
      else if (r_state == S_DRAIN && !w_drain_end)
        r_drain <= r_drain - 1'b1;
    end
  end

  assign io_seq.busy       = w_busy;
  assign io_seq.done       = w_done;
  assign io_seq.pass_idx   = r_pass_idx;
  assign io_seq.conv_start = w_start;
  // Engine is held in reset whenever the sequencer is.
  assign io_seq.conv_rst   = rst | w_clr | w_to_rst;

  conv_addr_offset #(.ADDR_W(ADDR_W)) u_addr_offset (
    .i_conv_raddr (io_seq.conv_raddr),
    .i_conv_waddr (io_seq.conv_waddr),
    .i_conv_we    (io_seq.conv_we),
    .i_src_cur    (r_src_cur),
    .i_dst_cur    (r_dst_cur),
    .i_we_en      (w_we_en),
    .o_mem_raddr  (io_seq.mem_raddr),
    .o_mem_waddr  (io_seq.mem_waddr),
    .o_mem_we     (io_seq.mem_we)
  );

endmodule
